// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, default widths and saturation bounds for the MAC accumulator.
package booth_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W = 16;
    localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
endpackage

// File: rtl/booth_sat_add.sv
// booth_sat_add: adds a sign-extended product to the accumulator and clamps to the ACC_W signed range.
module booth_sat_add #(
    parameter int PROD_W = 8,
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);
    logic signed [ACC_W:0] wide;
    assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    // one guard bit is enough: disagreement with the sign bit means the sum left the range
    assign ovf = wide[ACC_W] ^ wide[ACC_W-1];
    assign sum = !ovf ? wide[ACC_W-1:0] :
                 wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
endmodule

// File: rtl/booth_mac_accum.sv
// booth_mac_accum: sums N_TERMS signed products into a saturating accumulator
// and presents the result on a valid/ready port.
module booth_mac_accum
    import booth_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int N_TERMS = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_ovf,
    output logic                     busy,
    output logic [CNT_W-1:0]         term_cnt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS);
    state_t state;
    logic signed [ACC_W-1:0] sum;
    logic ovf;
    booth_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc(out_sum), .prod(in_prod), .sum(sum), .ovf(ovf)
    );
    assign in_ready = (state == ACCUM) && ena;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    // out_sum is the accumulator itself, so it holds its value after the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_sum <= '0;
            term_cnt <= '0;
            out_ovf <= 1'b0;
        end else if (ena) begin
            if (clear || (state == IDLE && start)) begin
                state <= clear ? IDLE : ACCUM;
                out_sum <= '0;
                term_cnt <= '0;
                out_ovf <= 1'b0;
            end else if (state == ACCUM && in_valid) begin
                out_sum <= sum;
                term_cnt <= term_cnt + 1'b1;
                out_ovf <= out_ovf | ovf;
                if (term_cnt + 1'b1 == LAST) state <= DONE;
            end else if (state == DONE && out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_booth_mac_accum.sv
// tb_booth_mac_accum: randomized and directed checks of two accumulators (16-bit and 8-bit) against a saturating sum model.
module tb_booth_mac_accum;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0, clear = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic signed [7:0] in_prod = '0;
    logic ir_a, ov_a, of_a, bz_a, ir_b, ov_b, of_b, bz_b;
    logic signed [15:0] sum_a;
    logic signed [7:0] sum_b;
    logic [7:0] cnt_a, cnt_b;
    int checks = 0, errors = 0;
    int pv[4];
    int e16, e8;
    bit o16, o8;

    always #5 clk = ~clk;

    booth_mac_accum dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(ir_a), .in_prod(in_prod), .out_valid(ov_a),
        .out_ready(out_ready), .out_sum(sum_a), .out_ovf(of_a), .busy(bz_a), .term_cnt(cnt_a)
    );
    booth_mac_accum #(.ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(ir_b), .in_prod(in_prod), .out_valid(ov_b),
        .out_ready(out_ready), .out_sum(sum_b), .out_ovf(of_b), .busy(bz_b), .term_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int a, input int p, input int w, inout bit o);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        int s = a + p;
        if (s > hi) begin s = hi; o = 1'b1; end
        else if (s < lo) begin s = lo; o = 1'b1; end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int cnt, input bit valid, input bit bz);
        chk({tag, "_sum_a"}, sum_a, e16);
        chk({tag, "_sum_b"}, sum_b, e8);
        chk({tag, "_ovf_a"}, of_a, o16);
        chk({tag, "_ovf_b"}, of_b, o8);
        chk({tag, "_cnt_a"}, cnt_a, cnt);
        chk({tag, "_cnt_b"}, cnt_b, cnt);
        chk({tag, "_valid_a"}, ov_a, valid);
        chk({tag, "_valid_b"}, ov_b, valid);
        chk({tag, "_busy_a"}, bz_a, bz);
        chk({tag, "_busy_b"}, bz_b, bz);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        e16 = 0; e8 = 0; o16 = 1'b0; o8 = 1'b0;
        chk_all("start", 0, 1'b0, 1'b1);
    endtask

    // mode 0: steady, 1: in_valid toggles, 2: random valid/ena, 3: ena low for 3 cycles after 2 beats
    task automatic feed(input int n, input int mode);
        int k = 0;
        int c = 0;
        while (k < n && c < 200) begin
            ena = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 3) ? !(c >= 2 && c < 5) : 1'b1;
            in_valid = (mode == 1) ? (c % 2 == 0) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_prod = 8'(pv[k]);
            #1;
            chk("in_ready_a", ir_a, ena);
            chk("in_ready_b", ir_b, ena);
            @(posedge clk);
            #1;
            if (ena && in_valid) begin
                e16 = sat(e16, pv[k], 16, o16);
                e8 = sat(e8, pv[k], 8, o8);
                k++;
            end
            c++;
            chk_all("beat", k, k == 4, 1'b1);
        end
        in_valid = 1'b0;
        ena = 1'b1;
        if (k < n) chk("feed_timeout", k, n);
    endtask

    task automatic finish_result(input int hold);
        out_ready = 1'b0;
        repeat (hold) begin
            tick();
            chk_all("hold", 4, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        ena = 1'b0;
        tick();
        chk_all("ena_gate", 4, 1'b1, 1'b1);
        ena = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_all("taken", 4, 1'b0, 1'b0);
    endtask

    task automatic run(input int mode, input int hold);
        do_start();
        feed(4, mode);
        finish_result(hold);
    endtask

    initial begin
        #12;
        e16 = 0; e8 = 0; o16 = 1'b0; o8 = 1'b0;
        chk_all("reset", 0, 1'b0, 1'b0);
        chk("reset_ready_a", ir_a, 0);
        #3 rst_n = 1'b1;
        tick();
        pv = '{21, -6, 49, -64};
        run(0, 0);
        pv = '{7, 7, 7, 7};
        run(1, 5);
        pv = '{100, 100, -50, 10};
        run(0, 1);
        chk("sat_b_87", sum_b, 87);
        pv = '{-128, -128, -128, -128};
        run(0, 0);
        chk("sat_b_min", sum_b, -128);
        // abort: two beats, ignored start, then clear (clear beats a simultaneous start)
        pv = '{5, -9, 0, 0};
        do_start();
        feed(2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ign_start", 2, 1'b0, 1'b1);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        e16 = 0; e8 = 0;
        chk_all("clear", 0, 1'b0, 1'b0);
        pv = '{1, 2, 3, 4};
        run(0, 0);
        chk("abort_sum10", sum_a, 10);
        pv = '{-33, 90, 17, -120};
        run(3, 2);
        // async reset between edges mid-accumulation
        pv = '{100, 100, 0, 0};
        do_start();
        feed(2, 0);
        #2 rst_n = 1'b0;
        #1;
        e16 = 0; e8 = 0; o16 = 1'b0; o8 = 1'b0;
        chk_all("async_rst", 0, 1'b0, 1'b0);
        chk("async_ready_a", ir_a, 0);
        #2 rst_n = 1'b1;
        tick();
        pv = '{21, -6, 49, -64};
        run(0, 0);
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 4; i++) pv[i] = int'($urandom_range(0, 255)) - 128;
            run(2, int'($urandom_range(0, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
